// File: rtl/triple_sampler.sv
// triple_sampler: oversampling front end for the 3-input majority voter.
// Aligns to the first transition on din, then captures three samples per bit
// period centred on the bit midpoint (cnt = DIV/2-GAP, DIV/2, DIV/2+GAP) and
// presents them as a/b/c with a valid/ready handshake and a sticky overrun flag.
// Build option: define TRIPLE_SAMPLER_SYNC_EN to insert a 2-flop synchronizer
// on din (adds 2 cycles of din-to-output latency; ports are unchanged).
module triple_sampler #(
  parameter int DIV = 16,
  parameter int GAP = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  input  logic out_ready,
  output logic a_out,
  output logic b_out,
  output logic c_out,
  output logic out_valid,
  output logic overrun
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] PT_A    = CW'(DIV / 2 - GAP);
  localparam logic [CW-1:0] PT_B    = CW'(DIV / 2);
  localparam logic [CW-1:0] PT_C    = CW'(DIV / 2 + GAP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          din_s;
  logic          din_q;
  logic          din_edge;
  logic          sa;
  logic          sb;
  logic          samp_a;
  logic          samp_b;
  logic          load;

`ifdef TRIPLE_SAMPLER_SYNC_EN
  logic sync1;
  logic sync2;

  // Two-flop synchronizer: din may be asynchronous to clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync1/sync2 a true two-stage
      // pipeline; blocking ones would collapse it into a single flop.
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign din_s = sync2;
`else
  assign din_s = din;
`endif

  // One-cycle delayed copy of din_s for transition detection.
  always_ff @(posedge clk) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din_s;
  end

  assign din_edge = din_s ^ din_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: en low forces IDLE; alignment happens once per enable.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned,
    // which would otherwise infer a latch.
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nx = ALIGN;
        ALIGN:   if (din_edge) state_nx = SAMPLE;
        SAMPLE:  state_nx = SAMPLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output decode: sample-point strobes, only while enabled in SAMPLE.
  always_comb begin
    samp_a = 1'b0;
    samp_b = 1'b0;
    load   = 1'b0;
    if (en && state == SAMPLE) begin
      samp_a = (cnt == PT_A);
      samp_b = (cnt == PT_B);
      load   = (cnt == PT_C);
    end
  end

  // Bit-phase counter: runs only in SAMPLE, wrapping once per bit period.
  always_ff @(posedge clk) begin
    if (!rst_n || !en)        cnt <= '0;
    else if (state == SAMPLE) cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    else                      cnt <= '0;
  end

  // Shadow samples, output triple, handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every flop here is plain control/data state (no memory array),
      // so all of it is reset to give known outputs straight after reset.
      sa        <= 1'b0;
      sb        <= 1'b0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (samp_a) sa <= din_s;
      if (samp_b) sb <= din_s;
      if (load) begin
        a_out     <= sa;
        b_out     <= sb;
        c_out     <= din_s;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (!en) begin
        out_valid <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_triple_sampler.sv
// Self-checking bench for triple_sampler (DIV=16, GAP=1).
// Table-driven bit vectors plus hand-written sequences for reset, overrun,
// en drop and mid-bit reset. Timing expectations follow the synchronizer
// build option (TRIPLE_SAMPLER_SYNC_EN adds 2 cycles).
module tb_triple_sampler;

`ifdef TRIPLE_SAMPLER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int DIV = 16;
  localparam int NV  = 8;

  logic clk;
  logic rst_n;
  logic en;
  logic din;
  logic out_ready;
  logic a_out;
  logic b_out;
  logic c_out;
  logic out_valid;
  logic overrun;

  int tests;
  int failed;
  int ph;

  typedef struct {
    logic       lvl;
    int         glitch;
    logic [2:0] exp_abc;
    logic       exp_x;
  } vec_t;

  vec_t vecs [NV];

  triple_sampler #(.DIV(16), .GAP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (phase %0d)", name, act, exp, ph);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
  endtask

  // Reset, then enable so the DUT sits in ALIGN with din low.
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; din = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    tick();
  endtask

  // Drive a transition; phase 0 is the cycle after the edge is registered.
  task automatic align(input logic lvl);
    din = lvl;
    tick();
    ph = 0;
  endtask

  task automatic run_to(input int target, input logic lvl);
    while (ph < target) begin
      din = lvl;
      tick();
    end
  endtask

  initial begin
    tests = 0; failed = 0; ph = 0;
    rst_n = 1'b0; en = 1'b1; din = 1'b0; out_ready = 1'b1;

    vecs[0] = '{1'b1, -1, 3'b111, 1'b1};
    vecs[1] = '{1'b1,  8, 3'b101, 1'b1};
    vecs[2] = '{1'b1,  7, 3'b011, 1'b1};
    vecs[3] = '{1'b1,  9, 3'b110, 1'b1};
    vecs[4] = '{1'b0, -1, 3'b000, 1'b0};
    vecs[5] = '{1'b0,  8, 3'b010, 1'b0};
    vecs[6] = '{1'b0,  3, 3'b000, 1'b0};
    vecs[7] = '{1'b1, 12, 3'b111, 1'b1};

    // Reset with en high and din toggling.
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      tick();
    end
    check("rst_outputs", 8'({a_out, b_out, c_out, out_valid, overrun}), 8'h00);
    check("rst_state", 8'(dut.state), 8'h00);

    // Table-driven bit periods, consumer always ready.
    do_reset();
    align(1'b1);
    while (ph < NV * DIV + 12 + LAT) begin
      int v;
      int p;
      v = ph / DIV;
      p = ph % DIV;
      if (v < NV) din = (p == vecs[v].glitch) ? ~vecs[v].lvl : vecs[v].lvl;
      else        din = vecs[NV-1].lvl;
      tick();
      if (ph >= LAT) begin
        int v2;
        int p2;
        v2 = (ph - LAT) / DIV;
        p2 = (ph - LAT) % DIV;
        if (v2 < NV) begin
          if (p2 == 9)
            check($sformatf("v%0d_pre_valid", v2), 8'(out_valid), 8'h0);
          if (p2 == 10) begin
            check($sformatf("v%0d_triple", v2), 8'({out_valid, a_out, b_out, c_out}),
                  8'({1'b1, vecs[v2].exp_abc}));
            check($sformatf("v%0d_voter", v2), 8'(maj(a_out, b_out, c_out)), 8'(vecs[v2].exp_x));
          end
          if (p2 == 11)
            check($sformatf("v%0d_post_valid", v2), 8'(out_valid), 8'h0);
        end
      end
    end
    check("vec_no_overrun", 8'(overrun), 8'h0);

    // Backpressure: second triple overwrites the first and sets overrun.
    do_reset();
    out_ready = 1'b0;
    align(1'b1);
    run_to(10 + LAT, 1'b1);
    check("bp_first", 8'({out_valid, a_out, b_out, c_out, overrun}), 8'b11110);
    while (ph < 26 + LAT) begin
      din = (ph < DIV) ? 1'b1 : 1'b0;
      tick();
    end
    check("bp_second", 8'({out_valid, a_out, b_out, c_out, overrun}), 8'b10001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_accept", 8'({out_valid, overrun}), 8'b01);
    check("bp_hold", 8'({a_out, b_out, c_out}), 8'b000);

    // Reset mid-bit (cnt = 8 of the third bit) clears the sticky overrun.
    run_to(2 * DIV + 8 + LAT, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_clear", 8'({out_valid, overrun, a_out, b_out, c_out}), 8'h00);
    repeat (20) tick();
    check("midrst_no_triple", 8'(out_valid), 8'h0);

    // en drop at cnt = 8: no triple, and realignment needs a new edge.
    do_reset();
    align(1'b1);
    run_to(8 + LAT, 1'b1);
    en = 1'b0;
    tick();
    run_to(12 + LAT, 1'b1);
    check("endrop_no_triple", 8'({out_valid, a_out, b_out, c_out}), 8'h0);
    en = 1'b1;
    repeat (20) tick();
    check("reenable_no_edge", 8'(out_valid), 8'h0);
    align(1'b0);
    run_to(9 + LAT, 1'b0);
    check("realign_pre", 8'(out_valid), 8'h0);
    tick();
    check("realign_triple", 8'({out_valid, a_out, b_out, c_out}), 8'b1000);
    check("realign_overrun", 8'(overrun), 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
